// File: rtl/bunch_integrator_mux.sv
// Bunch integrator with per-output lane routing.
// Saturating sums over a programmed strobe window.
`timescale 1ns/1ps

module bunch_integrator_mux #(
    parameter int N_CH  = 6,
    parameter int N_OUT = 4,
    parameter int IN_W  = 13,
    parameter int ACC_W = 17,
    parameter int CNT_W = 7,
    parameter int SEL_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic                   bunch_strb,
    input  logic                   dac_cond,
    input  logic [CNT_W-1:0]       n_bunch_cfg,
    input  logic [N_OUT*SEL_W-1:0] sel,
    input  logic [N_CH*IN_W-1:0]   in_data,
    output logic [N_OUT*ACC_W-1:0] acc_out,
    output logic                   out_valid,
    output logic                   busy,
    output logic [N_OUT-1:0]       sat_flag,
    output logic [CNT_W-1:0]       bunch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_HOLD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N_OUT*SEL_W-1:0] sel_q;
    logic [CNT_W-1:0]       cfg_q;
    logic [ACC_W-1:0]       acc     [N_OUT];
    logic [ACC_W-1:0]       acc_nxt [N_OUT];
    logic [IN_W-1:0]        lane    [N_OUT];
    logic [ACC_W:0]         sum     [N_OUT];
    logic [N_OUT-1:0]       sat_hit;
    logic                   take;
    logic                   last;
    logic                   done_q;
    logic                   start;

    assign start = (state == S_IDLE) && arm && !dac_cond;
    assign take  = (state == S_ACC) && bunch_strb && !dac_cond;
    assign last  = (bunch_cnt + CNT_W'(1)) == cfg_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; dac_cond dominates in every state
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (arm && !dac_cond) state_nxt = S_ACC;
            S_ACC: begin
                if (dac_cond)
                    state_nxt = S_IDLE;
                else if (bunch_strb && last)
                    state_nxt = S_HOLD;
            end
            S_HOLD: if (dac_cond) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == S_ACC);
    end

    // Lane routing and saturating add; out-of-range selects give 0
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            lane[k] = '0;
            for (int j = 0; j < N_CH; j++) begin
                if (sel_q[k*SEL_W +: SEL_W] == SEL_W'(j))
                    lane[k] = in_data[j*IN_W +: IN_W];
            end
            sum[k] = {acc[k][ACC_W-1], acc[k]}
                   + {{(ACC_W+1-IN_W){lane[k][IN_W-1]}}, lane[k]};
            sat_hit[k] = sum[k][ACC_W] ^ sum[k][ACC_W-1];
            if (!sat_hit[k])
                acc_nxt[k] = sum[k][ACC_W-1:0];
            else if (sum[k][ACC_W])
                acc_nxt[k] = {1'b1, {(ACC_W-1){1'b0}}};
            else
                acc_nxt[k] = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // Window config, accumulators and snapshot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            sat_flag  <= '0;
            bunch_cnt <= '0;
            sel_q     <= '0;
            cfg_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= take && last;
            out_valid <= 1'b0;
            if (start) begin
                sel_q     <= sel;
                bunch_cnt <= '0;
                sat_flag  <= '0;
                cfg_q     <= (n_bunch_cfg == '0) ? CNT_W'(1)
                                                 : n_bunch_cfg;
            end
            if (dac_cond) begin
                for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
            end else if (take) begin
                for (int k = 0; k < N_OUT; k++) acc[k] <= acc_nxt[k];
                sat_flag  <= sat_flag | sat_hit;
                bunch_cnt <= bunch_cnt + CNT_W'(1);
            end
            if (done_q && (state == S_HOLD) && !dac_cond) begin
                for (int k = 0; k < N_OUT; k++)
                    acc_out[k*ACC_W +: ACC_W] <= acc[k];
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bunch_integrator_mux.md
Name: bunch_integrator_mux

Overview:
- Parametrised successor to the fixed 4-output BPM mux/integrator.
- Routes any of N_CH signed ADC lanes to each of N_OUT integrators through a per-output select.
- Integrates the selected samples over a programmed number of bunch strobes with saturating arithmetic.
- Presents a frozen snapshot of the sums with a one-cycle valid strobe. Sits between the demodulated I/Q lanes and the feedback/DAC calculation logic.

Parameters:
- N_CH, 6, number of input lanes
- N_OUT, 4, number of integrators/outputs
- IN_W, 13, signed input sample width
- ACC_W, 17, signed accumulator/output width (ACC_W >= IN_W+1)
- CNT_W, 7, width of bunch counter and n_bunch_cfg
- SEL_W, 3, select width per output (2^SEL_W >= N_CH)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  start an integration window (pulse)
- bunch_strb  in  1  sample-valid strobe; one accumulation per high cycle
- dac_cond  in  1  clear/abort; returns block to IDLE
- n_bunch_cfg  in  CNT_W  strobes per window; 0 treated as 1
- sel  in  N_OUT*SEL_W  per-output lane select, output k uses bits [k*SEL_W +: SEL_W]
- in_data  in  N_CH*IN_W  signed lanes, lane j at [j*IN_W +: IN_W]
- acc_out  out  N_OUT*ACC_W  signed snapshot sums, output k at [k*ACC_W +: ACC_W]
- out_valid  out  1  one-cycle pulse when acc_out updates
- busy  out  1  high in ACC state
- sat_flag  out  N_OUT  sticky per-output saturation indication for the current window
- bunch_cnt  out  CNT_W  strobes accumulated in current window

Behaviour:
- Reset (rst_n low, async): state=IDLE; accumulators, acc_out, bunch_cnt, sat_flag = 0; out_valid=0; busy=0; latched selects=0.
- FSM states are IDLE, ACC and HOLD.
- IDLE:
  - Accumulators held at 0.
  - arm=1 and dac_cond=0 -> ACC next cycle. On that same edge: latch sel into internal select registers, clear bunch_cnt and sat_flag, and latch n_bunch_cfg (0 -> 1).
  - bunch_strb ignored.
- ACC:
  - On each bunch_strb=1 cycle, every accumulator k adds the sign-extended lane selected by latched sel k, and bunch_cnt increments.
  - A latched select >= N_CH contributes 0.
  - Live sel changes during ACC have no effect.
- Termination:
  - On the strobe that makes bunch_cnt equal the latched count, go to HOLD.
  - On the next edge, acc_out loads the final sums (including that strobe) and out_valid=1 for exactly one cycle.
  - Latency is 2 clk edges from the final strobe to out_valid high.
- Saturation:
  - If a sum exceeds 2^(ACC_W-1)-1 or falls below -2^(ACC_W-1), the accumulator clamps to that bound and the matching sat_flag bit sets.
  - The sat_flag bit stays set until the next arm.
  - There is no wrap-around.
- HOLD:
  - acc_out, sat_flag and bunch_cnt stay frozen.
  - arm and bunch_strb are ignored.
  - dac_cond=1 -> IDLE and accumulators zeroed. acc_out keeps its last value until the next window completes.
- Abort:
  - dac_cond=1 in ACC -> IDLE.
  - Accumulators are zeroed, no out_valid, and acc_out is unchanged.
- Priority: dac_cond beats bunch_strb and arm in the same cycle, in every state.
- arm while in ACC is ignored; no restart.
- busy=1 exactly while state=ACC.
- acc_out is registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then arm with n_bunch_cfg=4 and sel out0 = lane0. Drive lane0=+100 on 4 strobes spaced 3 cycles -> out_valid pulses once, acc_out[0]=400, bunch_cnt=4, busy low after the 4th strobe.
- Cross-routing: sel = {5,3,1,0}, lanes j = j*10-20, n_bunch_cfg=2 -> out0=-40, out1=-20, out2=20, out3=60. Changing sel mid-window leaves these results unchanged.
- Saturation: lane0=+4095, n_bunch_cfg=40 -> acc_out[0]=65535 and sat_flag[0]=1. Repeat with -4096 -> -65536. The next arm clears sat_flag.
- Abort and priority:
  - dac_cond asserted on the same cycle as the 2nd of 4 strobes -> IDLE, no out_valid, acc_out holds the prior window value.
  - dac_cond and arm together in IDLE -> stays IDLE.
- Edge config: n_bunch_cfg=0 -> window ends after 1 strobe. A select value of 7 (>= N_CH) gives 0 on that output.
- Async reset mid-ACC (rst_n low between edges) -> all outputs 0 immediately, state IDLE. Strobes after release are ignored until arm.
